// File: rtl/sift_pkg.sv
// Shared constants, FSM state encoding and sample-tag record for the window_rotate control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   SIFT_NSAMP / ROTATE_LAT / SIFT_ADDR_W / NDIR : default geometry of the rotate window
//   rot_state_t : controller state encoding
//   smp_tag_t   : {valid, idx, last} record carried alongside the datapath
package sift_pkg;

    localparam int SIFT_NSAMP  = 256;  // samples per descriptor window
    localparam int ROTATE_LAT  = 3;    // datapath latency, rot_cnt cycle -> addr_out cycle
    localparam int SIFT_ADDR_W = 18;   // keypoint / image address width
    localparam int NDIR        = 36;   // legal main-direction bins 0..NDIR-1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rot_state_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] idx;
        logic       last;
    } smp_tag_t;

endpackage

// File: rtl/window_rotate_ctrl_tag_pipe.sv
// Shift register carrying {valid, idx, last} tags in lockstep with the rotate datapath.
// Latency: DEPTH cycles from i_* to o_*.
// Backpressure: none; advances every cycle, rst clears all stages synchronously.
//
// Ports:
//   clk, rst              : clock, synchronous active-high clear
//   i_vld, i_idx, i_last  : tag entering stage 1 (the ISSUE-cycle view)
//   o_vld, o_idx, o_last  : tag leaving stage DEPTH (aligned to datapath addr_out)
module sample_tag_pipe
    import sift_pkg::*;
#(
    parameter int DEPTH = ROTATE_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_vld,
    input  logic [7:0] i_idx,
    input  logic       i_last,
    output logic       o_vld,
    output logic [7:0] o_idx,
    output logic       o_last
);

    smp_tag_t r_stage [DEPTH];
    smp_tag_t w_in;

    assign w_in.vld  = i_vld;
    assign w_in.idx  = i_idx;
    assign w_in.last = i_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= w_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_vld  = r_stage[DEPTH-1].vld;
    assign o_idx  = r_stage[DEPTH-1].idx;
    assign o_last = r_stage[DEPTH-1].last;

endmodule

// File: rtl/window_rotate_ctrl.sv
// Sequences the window_rotate datapath one keypoint at a time and tags its rotated addresses.
// Latency: first smp_valid LAT cycles after the first ISSUE cycle; NSAMP+LAT+1 cycles per keypoint.
// Backpressure: kp_ready only in IDLE; no downstream backpressure (one sample per cycle).
//
// Ports:
//   clk, rst                                   : clock, synchronous active-high reset
//   kp_valid/kp_ready                          : keypoint request handshake
//   kp_addr_in, main_dir_in, octave_sel        : keypoint request fields
//   rot_kp_addr, rot_main_dir, rot_complete1   : request fields held for the datapath
//   rot_cnt                                    : ROM sample index driven into the datapath
//   smp_valid, smp_idx, smp_last               : tags aligned with datapath addr_out
//   busy, done, err_dir                        : status; done/err_dir are one-cycle pulses
module window_rotate_ctrl #(
    parameter int NSAMP  = sift_pkg::SIFT_NSAMP,
    parameter int LAT    = sift_pkg::ROTATE_LAT,
    parameter int ADDR_W = sift_pkg::SIFT_ADDR_W,
    parameter int NDIR   = sift_pkg::NDIR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kp_valid,
    output logic              kp_ready,
    input  logic [ADDR_W-1:0] kp_addr_in,
    input  logic [5:0]        main_dir_in,
    input  logic              octave_sel,
    output logic [ADDR_W-1:0] rot_kp_addr,
    output logic [5:0]        rot_main_dir,
    output logic              rot_complete1,
    output logic [7:0]        rot_cnt,
    output logic              smp_valid,
    output logic [7:0]        smp_idx,
    output logic              smp_last,
    output logic              busy,
    output logic              done,
    output logic              err_dir
);

    import sift_pkg::*;

    // Elaboration-time geometry checks: rot_cnt is 8 bits, drain counter is 4 bits.
    if (NSAMP < 1 || NSAMP > 256) begin : g_bad_nsamp
        $error("window_rotate_ctrl: NSAMP must be within 1..256");
    end
    if (LAT < 2 || LAT > 17) begin : g_bad_lat
        $error("window_rotate_ctrl: LAT must be within 2..17");
    end
    if (NDIR < 1 || NDIR > 64) begin : g_bad_ndir
        $error("window_rotate_ctrl: NDIR must be within 1..64");
    end

    localparam logic [7:0] LAST_CNT  = 8'(NSAMP - 1);
    localparam logic [3:0] DRAIN_END = 4'(LAT - 2);
    localparam logic [6:0] NDIR_W    = 7'(NDIR);

    rot_state_t        r_state;
    logic [ADDR_W-1:0] r_kp_addr;
    logic [5:0]        r_main_dir;
    logic              r_complete1;
    logic [7:0]        r_cnt;
    logic [3:0]        r_drain_cnt;
    logic              r_done;
    logic              r_err_dir;

    logic              w_accept;
    logic              w_dir_ok;
    logic              w_issue;
    logic              w_cnt_last;

    assign kp_ready   = (r_state == ST_IDLE) & ~rst;
    assign w_accept   = kp_valid & kp_ready;
    assign w_dir_ok   = ({1'b0, main_dir_in} < NDIR_W);
    assign w_issue    = (r_state == ST_ISSUE);
    assign w_cnt_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_kp_addr   <= '0;
            r_main_dir  <= '0;
            r_complete1 <= 1'b0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_err_dir   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_err_dir <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_dir_ok) begin
                            r_kp_addr   <= kp_addr_in;
                            r_main_dir  <= main_dir_in;
                            r_complete1 <= octave_sel;
                            r_cnt       <= '0;
                            r_state     <= ST_ISSUE;
                        end else begin
                            // Rejected request: held fields and rot_cnt are left untouched.
                            r_err_dir <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The counter parks on the final index instead of wrapping so the
                    // datapath never sees a spurious sample 0 while the pipe drains.
                    if (w_cnt_last) begin
                        r_drain_cnt <= '0;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_END) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    // done is registered, so it shows in the first IDLE cycle together
                    // with kp_ready; the last tag leaves the pipe the cycle before.
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rot_kp_addr   = r_kp_addr;
    assign rot_main_dir  = r_main_dir;
    assign rot_complete1 = r_complete1;
    assign rot_cnt       = r_cnt;
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign err_dir       = r_err_dir;

    sample_tag_pipe #(
        .DEPTH (LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_issue),
        .i_idx  (r_cnt),
        .i_last (w_issue & w_cnt_last),
        .o_vld  (smp_valid),
        .o_idx  (smp_idx),
        .o_last (smp_last)
    );

endmodule
